// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Instruction-memory fetch bundle between the PC sequencer and instruction
// memory.
//   imem_req  : fetch request (sequencer -> memory)
//   imem_addr : fetch address (sequencer -> memory)
//   imem_ack  : instruction word valid this cycle (memory -> sequencer)
//   ir_load   : load strobe for the instruction register (sequencer -> core)
// Modports:
//   master : the sequencer side
//   slave  : the memory / instruction-register side
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int PC_W = 13
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            ir_load;

  modport master (
    output imem_req,
    output imem_addr,
    output ir_load,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  ir_load,
    output imem_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle program-counter sequencer for the KGP_RISC core. Owns the PC,
// fetches through a req/ack handshake, resolves the next PC when the control
// unit reports exec_done, and parks the core in HALT on request.
//
// Build option: PC_SEQ_RAS_EN
//   defined   : RAS_DEPTH-entry return-address stack (call pushes pc+1,
//               ret pops; overflow/underflow set the sticky ras_err)
//   undefined : no stack; call acts as a taken branch, ret as pc+1,
//               ras_err is constant 0
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   imem         : fetch bundle (imem_req, imem_addr, imem_ack, ir_load)
//   exec_done    : current instruction resolved, next-PC inputs valid
//   br_taken     : conditional branch taken, target br_target
//   jr_en        : register jump, target jr_target
//   call / ret   : subroutine call to br_target / return
//   halt         : enter HALT after the current instruction
//   resume       : leave HALT
//   pc           : current PC
//   halted       : high while in HALT
//   ras_err      : sticky stack overflow/underflow flag
//
// state | meaning
// FETCH | imem_req high at pc, waiting for imem_ack
// EXEC  | instruction in flight, waiting for exec_done
// HALT  | pc frozen, waiting for resume
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W      = 13,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.master  imem,
  input  logic            exec_done,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jr_en,
  input  logic [PC_W-1:0] jr_target,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            ras_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] next_pc;
  logic            commit;

  // Natural PC_W-bit wrap gives 2^PC_W-1 -> 0.
  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign commit = (state_q == ST_EXEC) && exec_done;

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0]   RAS_FULL = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  // Circular buffer: sp_q is the next free slot, so when full the slot at
  // sp_q holds the oldest entry and a push overwrites it.
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ras_err_q, ras_err_d;
  logic             ras_push, ras_pop, ras_fault;

  always_comb begin
    next_pc   = pc_inc;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_fault = 1'b0;
    if (ret) begin
      if (cnt_q != '0) begin
        next_pc = ras_q[sp_q - PTR_ONE];
        ras_pop = 1'b1;
      end else begin
        ras_fault = 1'b1;
      end
    end else if (jr_en) begin
      next_pc = jr_target;
    end else if (call) begin
      next_pc  = br_target;
      ras_push = 1'b1;
      if (cnt_q == RAS_FULL) ras_fault = 1'b1;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

  always_comb begin
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    ras_err_d = ras_err_q | (commit & ras_fault);
    if (commit && ras_push) begin
      sp_d = sp_q + PTR_ONE;
      if (cnt_q != RAS_FULL) cnt_d = cnt_q + CNT_ONE;
    end else if (commit && ras_pop) begin
      sp_d  = sp_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      ras_err_q <= ras_err_d;
      if (commit && ras_push) ras_q[sp_q] <= pc_inc;
    end
  end

  assign ras_err = ras_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (RAS_DEPTH > 0);

  // Without a stack, call degenerates to a taken branch and ret to pc+1.
  always_comb begin
    next_pc = pc_inc;
    if (ret) begin
      next_pc = pc_inc;
    end else if (jr_en) begin
      next_pc = jr_target;
    end else if (call || br_taken) begin
      next_pc = br_target;
    end
  end

  assign ras_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_FETCH: begin
        if (imem.imem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          state_d = halt ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // The state resets to FETCH, so the request is masked by rst directly to
  // drop it the moment reset asserts; a pending ack is likewise ignored.
  assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign imem.ir_load   = (state_q == ST_FETCH) && imem.imem_ack && !rst;
  assign pc             = pc_q;
  assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int PC_W      = 13;
  localparam int RAS_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            exec_done = 1'b0, br_taken = 1'b0, jr_en = 1'b0;
  logic            call = 1'b0, ret = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [PC_W-1:0] br_target = '0, jr_target = '0;
  logic [PC_W-1:0] pc;
  logic            halted, ras_err;
  bit              mem_en = 1'b1;

  pc_sequencer_if #(.PC_W(PC_W)) imem_if ();

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(13'd0), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .imem(imem_if.master),
    .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
    .jr_en(jr_en), .jr_target(jr_target), .call(call), .ret(ret),
    .halt(halt), .resume(resume), .pc(pc), .halted(halted), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] addr;
    logic            err;
  } exp_t;

  exp_t            exp_q[$];
  int              errors = 0;
  int              checks = 0;
  logic [PC_W-1:0] pc_m;
  logic            err_m;
`ifdef PC_SEQ_RAS_EN
  logic [PC_W-1:0] ras_m[$];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: next PC straight from the priority rules, stack as a queue.
  function automatic logic [PC_W-1:0] model_next(input bit r, input bit j, input bit c,
                                                 input bit b, input logic [PC_W-1:0] bt,
                                                 input logic [PC_W-1:0] jt);
    logic [PC_W-1:0] inc;
    inc = PC_W'((int'(pc_m) + 1) % (1 << PC_W));
    if (r) begin
`ifdef PC_SEQ_RAS_EN
      if (ras_m.size() == 0) begin
        err_m = 1'b1;
        return inc;
      end
      return ras_m.pop_back();
`else
      return inc;
`endif
    end
    if (j) return jt;
    if (c) begin
`ifdef PC_SEQ_RAS_EN
      if (ras_m.size() == RAS_DEPTH) begin
        void'(ras_m.pop_front());
        err_m = 1'b1;
      end
      ras_m.push_back(inc);
`endif
      return bt;
    end
    if (b) return bt;
    return inc;
  endfunction

  // Instruction memory: acks a held request after a random delay; also
  // throws the odd stray ack while no request is pending.
  initial begin
    imem_if.imem_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      imem_if.imem_ack = 1'b0;
      if (mem_en) begin
        if (imem_if.imem_req) imem_if.imem_ack = ($urandom_range(0, 3) != 0);
        else                  imem_if.imem_ack = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: every accepted fetch is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ir_load", imem_if.ir_load, imem_if.imem_req && imem_if.imem_ack);
        if (imem_if.imem_req && imem_if.imem_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: actual addr=%0h required none", imem_if.imem_addr);
          end else begin
            e = exp_q.pop_front();
            check("fetch_addr", imem_if.imem_addr, e.addr);
            check("fetch_pc", pc, e.addr);
            check("ras_err", ras_err, e.err);
          end
        end
      end
    end
  end

  // Called with rst already high: checks reset outputs, then releases.
  task automatic reset_release();
    check("rst_req", imem_if.imem_req, 1'b0);
    check("rst_pc", pc, 13'h0000);
    check("rst_addr", imem_if.imem_addr, 13'h0000);
    check("rst_ir_load", imem_if.ir_load, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_ras_err", ras_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    pc_m  = '0;
    err_m = 1'b0;
`ifdef PC_SEQ_RAS_EN
    ras_m.delete();
`endif
    exp_q.delete();
    exp_q.push_back('{addr: 13'h0000, err: 1'b0});
    mem_en = 1'b1;
    rst    = 1'b0;
    #1;
    check("post_rst_req", imem_if.imem_req, 1'b1);
  endtask

  task automatic do_instr(input bit r, input bit j, input bit c, input bit b,
                          input logic [PC_W-1:0] bt, input logic [PC_W-1:0] jt,
                          input bit h, input bit stall);
    bit              seen;
    logic [PC_W-1:0] nxt;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (imem_if.imem_req && imem_if.imem_ack) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: actual no ack required ack within 100 cycles");
      return;
    end
    @(posedge clk); #1;
    check("exec_req", imem_if.imem_req, 1'b0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    nxt  = model_next(r, j, c, b, bt, jt);
    pc_m = nxt;
    exp_q.push_back('{addr: nxt, err: err_m});
    exec_done = 1'b1; ret = r; jr_en = j; call = c; br_taken = b;
    br_target = bt; jr_target = jt; halt = h;
    resume = h ? 1'b0 : 1'($urandom_range(0, 1));
    if (stall) mem_en = 1'b0;
    @(posedge clk); #1;
    {exec_done, ret, jr_en, call, br_taken, halt, resume} = '0;
    if (h) begin
      for (int i = 0; i < 10; i++) begin
        check("halt_halted", halted, 1'b1);
        check("halt_req", imem_if.imem_req, 1'b0);
        check("halt_pc", pc, pc_m);
        // Junk on every control input; only resume may matter in HALT.
        {exec_done, ret, jr_en, call, br_taken} = '1;
        br_target = PC_W'($urandom);
        jr_target = PC_W'($urandom);
        @(posedge clk); #1;
      end
      {exec_done, ret, jr_en, call, br_taken} = '0;
      resume = 1'b1;
      @(posedge clk); #1;
      resume = 1'b0;
      check("resume_req", imem_if.imem_req, 1'b1);
      check("resume_addr", imem_if.imem_addr, pc_m);
      check("resume_halted", halted, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    reset_release();

    repeat (4) do_instr(0, 0, 0, 0, '0, '0, 0, 0);
    do_instr(0, 0, 0, 1, 13'h1FFF, 13'h0000, 0, 0);
    do_instr(0, 0, 0, 0, 13'h0AAA, 13'h0555, 0, 0);
    do_instr(0, 1, 0, 1, 13'h0040, 13'h0100, 0, 0);
    do_instr(0, 0, 0, 1, 13'h0010, 13'h0000, 0, 0);
    do_instr(0, 0, 1, 0, 13'h0200, 13'h0000, 0, 0);
    do_instr(1, 0, 0, 0, 13'h0000, 13'h0000, 0, 0);
    do_instr(1, 0, 0, 0, 13'h0000, 13'h0000, 0, 0);
    do_instr(0, 0, 0, 1, 13'h0005, 13'h0000, 0, 0);
    do_instr(0, 0, 0, 0, 13'h0000, 13'h0000, 1, 0);

    // Reset while a fetch is being requested at 0x0123.
    do_instr(0, 0, 0, 1, 13'h0123, 13'h0000, 0, 1);
    check("pre_rst_req", imem_if.imem_req, 1'b1);
    check("pre_rst_addr", imem_if.imem_addr, 13'h0123);
    #2;
    rst = 1'b1;
    #1;
    reset_release();

    for (int n = 0; n < 300; n++) begin
      do_instr($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
               PC_W'($urandom), PC_W'($urandom),
               $urandom_range(0, 19) == 0, 0);
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
